// File: rtl/mips_register_file.sv
// MIPS general-purpose register file: 32 x 32-bit entries, two combinational
// read ports, one synchronous write port. Register 0 always reads zero.
// A write in flight is forwarded to a read port addressing the same register,
// so decode sees write-back data in the same cycle it is being written.
module mips_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Entry 0 is cleared by reset and never written, so it stays zero; reads of
  // index 0 are also forced to zero explicitly below.
  logic [DATA_WIDTH-1:0] regFile [0:DEPTH-1];

  logic writeActive;
  logic fwd1;
  logic fwd2;

  // A write only counts when out of reset and aimed at a real register.
  assign writeActive = rst && write && (WriteRegister != '0);

  // Forward the pending write data when a port reads the register being written.
  assign fwd1 = writeActive && (WriteRegister == ReadRegister1);
  assign fwd2 = writeActive && (WriteRegister == ReadRegister2);

  // Storage: asynchronous clear of every entry, otherwise one write per edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regFile[i] <= '0;
      end
    end else if (writeActive) begin
      regFile[WriteRegister] <= WriteData;
    end
  end

  // Read port 1: zero in reset or for index 0, forwarded data, else storage.
  always_comb begin
    ReadData1 = '0;
    if (rst && (ReadRegister1 != '0)) begin
      if (fwd1) begin
        ReadData1 = WriteData;
      end else begin
        ReadData1 = regFile[ReadRegister1];
      end
    end
  end

  // Read port 2: identical selection, independent of port 1.
  always_comb begin
    ReadData2 = '0;
    if (rst && (ReadRegister2 != '0)) begin
      if (fwd2) begin
        ReadData2 = WriteData;
      end else begin
        ReadData2 = regFile[ReadRegister2];
      end
    end
  end

endmodule

// File: tb/tb_mips_register_file.sv
// Directed self-checking bench for mips_register_file.
module tb_mips_register_file;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  logic                  clk;
  logic                  rst;
  logic                  write;
  logic [ADDR_WIDTH-1:0] ReadRegister1;
  logic [ADDR_WIDTH-1:0] ReadRegister2;
  logic [ADDR_WIDTH-1:0] WriteRegister;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [DATA_WIDTH-1:0] ReadData1;
  logic [DATA_WIDTH-1:0] ReadData2;

  int testsRun;
  int testsFailed;

  mips_register_file #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .write        (write),
    .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeReg(input logic [ADDR_WIDTH-1:0] idx, input logic [DATA_WIDTH-1:0] val);
    write = 1'b1;
    WriteRegister = idx;
    WriteData = val;
    tick();
    write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    write = 1'b1;
    WriteRegister = 5'd3;
    WriteData = 32'hDEADBEEF;
    ReadRegister1 = 5'd3;
    ReadRegister2 = 5'd3;
    repeat (4) tick();
    testsRun++;
    if (ReadData1 !== 32'h0) begin
      testsFailed++;
      $display("FAIL reset_rd1_idx3: got %h expected %h", ReadData1, 32'h0);
    end
    testsRun++;
    if (ReadData2 !== 32'h0) begin
      testsFailed++;
      $display("FAIL reset_rd2_idx3_nofwd: got %h expected %h", ReadData2, 32'h0);
    end
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = i[4:0];
      ReadRegister2 = 5'd31 - i[4:0];
      #1;
      testsRun++;
      if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
        testsFailed++;
        $display("FAIL reset_all_idx%0d: got %h/%h expected 0/0", i, ReadData1, ReadData2);
      end
    end
    write = 1'b0;
    #1;
    rst = 1'b1;
    ReadRegister1 = 5'd3;
    tick();
    testsRun++;
    if (ReadData1 !== 32'h0) begin
      testsFailed++;
      $display("FAIL reset_release_idx3: got %h expected %h", ReadData1, 32'h0);
    end
  endtask

  task automatic test_basic_write();
    writeReg(5'd1, 32'h00000001);
    writeReg(5'd2, 32'h00000002);
    ReadRegister1 = 5'd1;
    ReadRegister2 = 5'd2;
    #1;
    testsRun++;
    if (ReadData1 !== 32'h00000001) begin
      testsFailed++;
      $display("FAIL basic_rd1_reg1: got %h expected %h", ReadData1, 32'h00000001);
    end
    testsRun++;
    if (ReadData2 !== 32'h00000002) begin
      testsFailed++;
      $display("FAIL basic_rd2_reg2: got %h expected %h", ReadData2, 32'h00000002);
    end
    // Swap addresses: outputs must follow with no clock edge.
    ReadRegister1 = 5'd2;
    ReadRegister2 = 5'd1;
    #1;
    testsRun++;
    if (ReadData1 !== 32'h00000002 || ReadData2 !== 32'h00000001) begin
      testsFailed++;
      $display("FAIL basic_swap: got %h/%h expected 00000002/00000001", ReadData1, ReadData2);
    end
  endtask

  task automatic test_reg_zero();
    write = 1'b1;
    WriteRegister = 5'd0;
    WriteData = 32'hFFFFFFFF;
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;
    #1;
    testsRun++;
    if (ReadData2 !== 32'h0) begin
      testsFailed++;
      $display("FAIL zero_nofwd_rd2: got %h expected %h", ReadData2, 32'h0);
    end
    tick();
    write = 1'b0;
    #1;
    testsRun++;
    if (ReadData1 !== 32'h0) begin
      testsFailed++;
      $display("FAIL zero_after_write_rd1: got %h expected %h", ReadData1, 32'h0);
    end
    ReadRegister1 = 5'd1;
    #1;
    testsRun++;
    if (ReadData1 !== 32'h00000001) begin
      testsFailed++;
      $display("FAIL zero_write_disturbed_reg1: got %h expected %h", ReadData1, 32'h00000001);
    end
  endtask

  task automatic test_write_disabled();
    writeReg(5'd5, 32'h12345678);
    write = 1'b0;
    WriteRegister = 5'd5;
    WriteData = 32'hAAAAAAAA;
    ReadRegister2 = 5'd5;
    #1;
    testsRun++;
    if (ReadData2 !== 32'h12345678) begin
      testsFailed++;
      $display("FAIL wdis_no_fwd_rd2: got %h expected %h", ReadData2, 32'h12345678);
    end
    tick();
    ReadRegister1 = 5'd5;
    #1;
    testsRun++;
    if (ReadData1 !== 32'h12345678) begin
      testsFailed++;
      $display("FAIL wdis_hold_reg5: got %h expected %h", ReadData1, 32'h12345678);
    end
  endtask

  task automatic test_forwarding();
    writeReg(5'd7, 32'h11111111);
    write = 1'b1;
    WriteRegister = 5'd7;
    WriteData = 32'h22222222;
    ReadRegister1 = 5'd7;
    ReadRegister2 = 5'd7;
    #1;
    testsRun++;
    if (ReadData1 !== 32'h22222222 || ReadData2 !== 32'h22222222) begin
      testsFailed++;
      $display("FAIL fwd_pre_edge: got %h/%h expected 22222222/22222222", ReadData1, ReadData2);
    end
    tick();
    write = 1'b0;
    #1;
    testsRun++;
    if (ReadData1 !== 32'h22222222 || ReadData2 !== 32'h22222222) begin
      testsFailed++;
      $display("FAIL fwd_post_edge: got %h/%h expected 22222222/22222222", ReadData1, ReadData2);
    end
    // Only port 2 matches the pending write; port 1 reads stored reg7.
    write = 1'b1;
    WriteRegister = 5'd8;
    WriteData = 32'hCAFEF00D;
    ReadRegister1 = 5'd7;
    ReadRegister2 = 5'd8;
    #1;
    testsRun++;
    if (ReadData1 !== 32'h22222222 || ReadData2 !== 32'hCAFEF00D) begin
      testsFailed++;
      $display("FAIL fwd_independent: got %h/%h expected 22222222/cafef00d", ReadData1, ReadData2);
    end
    tick();
    write = 1'b0;
    ReadRegister1 = 5'd8;
    #1;
    testsRun++;
    if (ReadData1 !== 32'hCAFEF00D) begin
      testsFailed++;
      $display("FAIL fwd_reg8_stored: got %h expected %h", ReadData1, 32'hCAFEF00D);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_WIDTH-1:0] exp1;
    logic [DATA_WIDTH-1:0] exp2;
    for (int i = 1; i < 32; i++) begin
      write = 1'b1;
      WriteRegister = i[4:0];
      WriteData = 32'(i);
      tick();
    end
    write = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = i[4:0];
      ReadRegister2 = 5'd31 - i[4:0];
      exp1 = 32'(i);
      exp2 = 32'(31 - i);
      #1;
      testsRun++;
      if (ReadData1 !== exp1 || ReadData2 !== exp2) begin
        testsFailed++;
        $display("FAIL b2b_read_idx%0d: got %h/%h expected %h/%h", i, ReadData1, ReadData2, exp1, exp2);
      end
    end
    // Full-width value in the top register.
    writeReg(5'd31, 32'hFFFFFFFF);
    ReadRegister1 = 5'd31;
    ReadRegister2 = 5'd30;
    #1;
    testsRun++;
    if (ReadData1 !== 32'hFFFFFFFF || ReadData2 !== 32'd30) begin
      testsFailed++;
      $display("FAIL b2b_reg31_full: got %h/%h expected ffffffff/0000001e", ReadData1, ReadData2);
    end
    // Async reset pulsed between edges.
    ReadRegister2 = 5'd17;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    testsRun++;
    if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
      testsFailed++;
      $display("FAIL midrun_reset_immediate: got %h/%h expected 0/0", ReadData1, ReadData2);
    end
    #1;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = i[4:0];
      #1;
      testsRun++;
      if (ReadData1 !== 32'h0) begin
        testsFailed++;
        $display("FAIL midrun_cleared_idx%0d: got %h expected %h", i, ReadData1, 32'h0);
      end
    end
    tick();
    ReadRegister1 = 5'd31;
    #1;
    testsRun++;
    if (ReadData1 !== 32'h0) begin
      testsFailed++;
      $display("FAIL midrun_reg31_after: got %h expected %h", ReadData1, 32'h0);
    end
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    rst = 1'b0;
    write = 1'b0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;
    WriteRegister = '0;
    WriteData = '0;
    #2;
    test_reset();
    test_basic_write();
    test_reg_zero();
    test_write_disabled();
    test_forwarding();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
